// File: rtl/riscv_mem_arb.sv
// riscv_mem_arb: shares one 32-bit memory port between the core's instruction
// fetch and data (LSU) ports with one transaction outstanding at a time.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// data has fixed priority over instruction fetch.
module riscv_mem_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_rd_i,
    input  logic [31:0] i_pc_i,
    output logic        i_accept_o,
    output logic        i_valid_o,
    input  logic        d_rd_i,
    input  logic [3:0]  d_wr_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_wr_i,
    input  logic [10:0] d_req_tag_i,
    output logic        d_accept_o,
    output logic        d_ack_o,
    output logic [10:0] d_resp_tag_o,
    output logic [31:0] resp_data_o,
    output logic        resp_error_o,
    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_wr_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_rd_i,
    input  logic        mem_error_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOCK, ST_WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IFETCH, OWN_DATA} owner_t;

    localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);

    state_t          state_reg, state_next;
    owner_t          owner_reg, owner_next;
    logic [10:0]     tag_reg, tag_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    owner_t          arb_owner;
    owner_t          grant;
    logic            d_req;
    logic            pick_data;
    logic            expire;

`ifdef MEM_ARB_RR_EN
    // Set when data holds priority, i.e. ifetch was the last requester granted.
    logic            rr_data_first_reg, rr_data_first_next;
`endif

    // A write (any byte enable) takes precedence over a simultaneous read.
    assign d_req  = d_rd_i | (|d_wr_i);
    assign expire = TO_EN && (cnt_reg == '0);

    // Arbitration: who would win if the arbiter were free this cycle.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        pick_data = d_req && (!i_rd_i || rr_data_first_reg);
`else
        pick_data = d_req;
`endif
        if (pick_data) begin
            arb_owner = OWN_DATA;
        end else if (i_rd_i) begin
            arb_owner = OWN_IFETCH;
        end else begin
            arb_owner = OWN_NONE;
        end
    end

    // Grant: live arbitration in IDLE, frozen owner while locked, nobody in WAIT.
    always_comb begin
        case (state_reg)
            ST_IDLE: grant = arb_owner;
            ST_LOCK: grant = owner_reg;
            default: grant = OWN_NONE;
        endcase
    end

    // State register and captured transaction context.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
            owner_reg <= OWN_NONE;
            tag_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            tag_reg   <= tag_next;
            cnt_reg   <= cnt_next;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin pointer; data is preferred out of reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_data_first_reg <= 1'b1;
        end else begin
            rr_data_first_reg <= rr_data_first_next;
        end
    end
`endif

    // Next-state, downstream request drive and response routing.
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        tag_next      = tag_reg;
        cnt_next      = cnt_reg;
`ifdef MEM_ARB_RR_EN
        rr_data_first_next = rr_data_first_reg;
`endif
        i_accept_o    = 1'b0;
        i_valid_o     = 1'b0;
        d_accept_o    = 1'b0;
        d_ack_o       = 1'b0;
        d_resp_tag_o  = '0;
        resp_data_o   = '0;
        resp_error_o  = 1'b0;
        mem_rd_o      = 1'b0;
        mem_wr_o      = '0;
        mem_addr_o    = '0;
        mem_data_wr_o = '0;

        case (grant)
            OWN_DATA: begin
                mem_rd_o      = d_rd_i && (d_wr_i == 4'h0);
                mem_wr_o      = d_wr_i;
                mem_addr_o    = d_addr_i;
                mem_data_wr_o = d_data_wr_i;
            end
            OWN_IFETCH: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = i_pc_i;
            end
            default: ;
        endcase

        case (state_reg)
            ST_IDLE, ST_LOCK: begin
                if (grant != OWN_NONE) begin
                    owner_next = grant;
                    if (mem_accept_i) begin
                        i_accept_o = (grant == OWN_IFETCH);
                        d_accept_o = (grant == OWN_DATA);
                        if (grant == OWN_DATA) begin
                            tag_next = d_req_tag_i;
                        end
                        cnt_next   = CW'(TIMEOUT);
                        state_next = ST_WAIT;
`ifdef MEM_ARB_RR_EN
                        rr_data_first_next = (grant == OWN_IFETCH);
`endif
                    end else begin
                        state_next = ST_LOCK;
                    end
                end
            end
            ST_WAIT: begin
                // A real ack beats an expiring counter in the same cycle.
                if (mem_ack_i || expire) begin
                    i_valid_o    = (owner_reg == OWN_IFETCH);
                    d_ack_o      = (owner_reg == OWN_DATA);
                    resp_data_o  = mem_ack_i ? mem_data_rd_i : 32'h0;
                    resp_error_o = mem_ack_i ? mem_error_i : 1'b1;
                    d_resp_tag_o = (owner_reg == OWN_DATA) ? tag_reg : 11'h0;
                    state_next   = ST_IDLE;
                    owner_next   = OWN_NONE;
                end else if (TO_EN) begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Keep every output quiet while reset is asserted, even in IDLE.
        if (!rst_i) begin
            i_accept_o    = 1'b0;
            i_valid_o     = 1'b0;
            d_accept_o    = 1'b0;
            d_ack_o       = 1'b0;
            d_resp_tag_o  = '0;
            resp_data_o   = '0;
            resp_error_o  = 1'b0;
            mem_rd_o      = 1'b0;
            mem_wr_o      = '0;
            mem_addr_o    = '0;
            mem_data_wr_o = '0;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arb.sv
// tb_riscv_mem_arb: directed scenarios plus randomized transactions checked
// against a transaction-level model of grant order, lock and timeout timing.
module tb_riscv_mem_arb;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        i_rd_i;
    logic [31:0] i_pc_i;
    logic        i_accept_o, i_valid_o;
    logic        d_rd_i;
    logic [3:0]  d_wr_i;
    logic [31:0] d_addr_i, d_data_wr_i;
    logic [10:0] d_req_tag_i;
    logic        d_accept_o, d_ack_o;
    logic [10:0] d_resp_tag_o;
    logic [31:0] resp_data_o;
    logic        resp_error_o;
    logic        mem_rd_o;
    logic [3:0]  mem_wr_o;
    logic [31:0] mem_addr_o, mem_data_wr_o;
    logic        mem_accept_i, mem_ack_i;
    logic [31:0] mem_data_rd_i;
    logic        mem_error_i;

    int n_cmp = 0;
    int n_bad = 0;
    bit last_data = 1'b0;   // 1 = data was the last requester granted

    riscv_mem_arb #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_rd_i(i_rd_i), .i_pc_i(i_pc_i), .i_accept_o(i_accept_o), .i_valid_o(i_valid_o),
        .d_rd_i(d_rd_i), .d_wr_i(d_wr_i), .d_addr_i(d_addr_i), .d_data_wr_i(d_data_wr_i),
        .d_req_tag_i(d_req_tag_i), .d_accept_o(d_accept_o), .d_ack_o(d_ack_o),
        .d_resp_tag_o(d_resp_tag_o), .resp_data_o(resp_data_o), .resp_error_o(resp_error_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_data_wr_o(mem_data_wr_o), .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i),
        .mem_data_rd_i(mem_data_rd_i), .mem_error_i(mem_error_i)
    );

    always #5 clk_i = ~clk_i;

    wire [1:0]   acc     = {i_accept_o, d_accept_o};
    wire [45:0]  resp    = {i_valid_o, d_ack_o, resp_error_o, resp_data_o, d_resp_tag_o};
    wire [68:0]  memb    = {mem_rd_o, mem_wr_o, mem_addr_o, mem_data_wr_o};
    wire [116:0] all_out = {acc, resp, memb};

    // Grant rule: the only requester wins; with both active, data wins under
    // fixed priority and the one not granted last wins under round-robin.
    function automatic bit pick_data(bit ireq, bit dreq);
`ifdef MEM_ARB_RR_EN
        if (ireq && dreq) return !last_data;
`endif
        return dreq;
    endfunction

    task automatic to_sample();
        @(negedge clk_i);
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        i_rd_i = 0; i_pc_i = 0; d_rd_i = 0; d_wr_i = 0; d_addr_i = 0; d_data_wr_i = 0;
        d_req_tag_i = 0; mem_accept_i = 0; mem_ack_i = 0; mem_data_rd_i = 0; mem_error_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 0;
        next_cycle();
        next_cycle();
        rst_i = 1;
        last_data = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 0;
        i_rd_i = 1; i_pc_i = 32'h80; d_rd_i = 1; d_addr_i = 32'h90; d_req_tag_i = 11'h3;
        mem_accept_i = 1; mem_ack_i = 1; mem_data_rd_i = 32'h5555_AAAA;
        for (int c = 0; c < 2; c++) begin
            to_sample();
            n_cmp++;
            if (all_out !== 117'h0) begin
                n_bad++;
                $display("FAIL reset_outputs cycle %0d: got %h, expected 0", c, all_out);
            end
            next_cycle();
        end
        clear_inputs();
        rst_i = 1;
        mem_ack_i = 1; mem_data_rd_i = 32'h1234;
        for (int c = 0; c < 2; c++) begin
            to_sample();
            n_cmp++;
            if (all_out !== 117'h0) begin
                n_bad++;
                $display("FAIL post_reset_idle cycle %0d: got %h, expected 0", c, all_out);
            end
            next_cycle();
        end
        $display("test_reset done");
    endtask

    task automatic test_dual_read();
        do_reset();
        i_rd_i = 1; i_pc_i = 32'h100; d_rd_i = 1; d_addr_i = 32'h2000; d_req_tag_i = 11'h005;
        mem_accept_i = 1;
        to_sample();
        n_cmp++;
        if (acc !== 2'b01) begin n_bad++; $display("FAIL dual_accept: got %b, expected 01", acc); end
        n_cmp++;
        if (memb !== {1'b1, 4'h0, 32'h2000, 32'h0}) begin
            n_bad++; $display("FAIL dual_mem: got %h, expected rd 0x2000", memb);
        end
        next_cycle();
        d_rd_i = 0;
        to_sample();
        n_cmp++;
        if ({acc, resp} !== 48'h0) begin n_bad++; $display("FAIL dual_wait1: got %h, expected 0", {acc, resp}); end
        next_cycle();
        mem_ack_i = 1; mem_data_rd_i = 32'hDEADBEEF;
        to_sample();
        n_cmp++;
        if (resp !== {1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 11'h005}) begin
            n_bad++; $display("FAIL dual_dresp: got %h, expected d_ack DEADBEEF tag 005", resp);
        end
        n_cmp++;
        if (acc !== 2'b00) begin n_bad++; $display("FAIL dual_bubble: got %b, expected 00", acc); end
        next_cycle();
        mem_ack_i = 0; mem_data_rd_i = 0;
        to_sample();
        n_cmp++;
        if ({acc, memb} !== {2'b10, 1'b1, 4'h0, 32'h100, 32'h0}) begin
            n_bad++; $display("FAIL dual_ifetch_grant: got %h, expected i_accept rd 0x100", {acc, memb});
        end
        next_cycle();
        i_rd_i = 0; mem_accept_i = 0; mem_ack_i = 1; mem_data_rd_i = 32'h13;
        to_sample();
        n_cmp++;
        if (resp !== {1'b1, 1'b0, 1'b0, 32'h13, 11'h0}) begin
            n_bad++; $display("FAIL dual_iresp: got %h, expected i_valid data 13", resp);
        end
        next_cycle();
        clear_inputs();
        $display("test_dual_read done");
    endtask

    task automatic test_lock();
        do_reset();
        d_rd_i = 1; d_wr_i = 4'hF; d_addr_i = 32'h3000; d_data_wr_i = 32'hA5A5A5A5; d_req_tag_i = 11'h123;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin i_rd_i = 1; i_pc_i = 32'h500; end
            mem_accept_i = (c == 3);
            to_sample();
            n_cmp++;
            if (memb !== {1'b0, 4'hF, 32'h3000, 32'hA5A5A5A5}) begin
                n_bad++; $display("FAIL lock_mem cycle %0d: got %h, expected wr F @3000", c, memb);
            end
            n_cmp++;
            if (acc !== ((c == 3) ? 2'b01 : 2'b00)) begin
                n_bad++; $display("FAIL lock_accept cycle %0d: got %b, expected %b", c, acc, (c == 3) ? 2'b01 : 2'b00);
            end
            next_cycle();
        end
        clear_inputs();
        mem_ack_i = 1;
        to_sample();
        n_cmp++;
        if (resp !== {1'b0, 1'b1, 1'b0, 32'h0, 11'h123}) begin
            n_bad++; $display("FAIL lock_resp: got %h, expected d_ack tag 123", resp);
        end
        next_cycle();
        clear_inputs();
        $display("test_lock done");
    endtask

    task automatic test_timeout();
        do_reset();
        d_rd_i = 1; d_addr_i = 32'h44; d_req_tag_i = 11'h2A; mem_accept_i = 1;
        to_sample();
        n_cmp++;
        if (acc !== 2'b01) begin n_bad++; $display("FAIL timeout_accept: got %b, expected 01", acc); end
        next_cycle();
        clear_inputs();
        for (int w = 1; w <= TO + 1; w++) begin
            mem_data_rd_i = $urandom; mem_error_i = 1'($urandom_range(0, 1));
            to_sample();
            n_cmp++;
            if (resp !== ((w == TO + 1) ? {1'b0, 1'b1, 1'b1, 32'h0, 11'h2A} : 46'h0)) begin
                n_bad++; $display("FAIL timeout_wait%0d: got %h, expected %s", w, resp, (w == TO + 1) ? "error pulse" : "none");
            end
            next_cycle();
        end
        mem_ack_i = 1; mem_data_rd_i = 32'h77;
        for (int c = 0; c < 2; c++) begin
            to_sample();
            n_cmp++;
            if (resp !== 46'h0) begin n_bad++; $display("FAIL timeout_late_ack %0d: got %h, expected 0", c, resp); end
            next_cycle();
        end
        clear_inputs();
        $display("test_timeout done");
    endtask

    task automatic test_arb_order();
        bit exp_d;
        int grants = 0;
        do_reset();
        i_rd_i = 1; i_pc_i = 32'h600; d_rd_i = 1; d_addr_i = 32'h700;
        mem_accept_i = 1; mem_ack_i = 1;
        for (int c = 0; c < 20 && grants < 4; c++) begin
            to_sample();
            if (acc != 2'b00) begin
                exp_d = pick_data(1'b1, 1'b1);
                n_cmp++;
                if (acc !== {!exp_d, exp_d}) begin
                    n_bad++; $display("FAIL arb_order grant %0d: got %b, expected %b", grants, acc, {!exp_d, exp_d});
                end
                $display("arb grant %0d -> %s", grants, d_accept_o ? "D" : "I");
                last_data = d_accept_o;
                grants++;
            end
            next_cycle();
        end
        n_cmp++;
        if (grants != 4) begin n_bad++; $display("FAIL arb_order_count: got %0d, expected 4", grants); end
        clear_inputs();
        next_cycle();
        $display("test_arb_order done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_rd_i = 1; i_pc_i = 32'h300; mem_accept_i = 1;
        to_sample();
        n_cmp++;
        if (acc !== 2'b10) begin n_bad++; $display("FAIL rstmid_accept: got %b, expected 10", acc); end
        next_cycle();
        clear_inputs();
        to_sample();
        n_cmp++;
        if (resp !== 46'h0) begin n_bad++; $display("FAIL rstmid_wait: got %h, expected 0", resp); end
        next_cycle();
        rst_i = 0; mem_ack_i = 1; mem_data_rd_i = 32'h1234;
        to_sample();
        n_cmp++;
        if (all_out !== 117'h0) begin n_bad++; $display("FAIL rstmid_in_reset: got %h, expected 0", all_out); end
        next_cycle();
        rst_i = 1;
        last_data = 1'b0;
        to_sample();
        n_cmp++;
        if (resp !== 46'h0) begin n_bad++; $display("FAIL rstmid_dropped: got %h, expected 0", resp); end
        next_cycle();
        mem_ack_i = 0; d_rd_i = 1; d_addr_i = 32'h40; d_req_tag_i = 11'h7FF; mem_accept_i = 1;
        to_sample();
        n_cmp++;
        if ({acc, memb} !== {2'b01, 1'b1, 4'h0, 32'h40, 32'h0}) begin
            n_bad++; $display("FAIL rstmid_next_accept: got %h, expected d_accept rd 0x40", {acc, memb});
        end
        next_cycle();
        clear_inputs();
        mem_ack_i = 1; mem_data_rd_i = 32'hCAFE;
        to_sample();
        n_cmp++;
        if (resp !== {1'b0, 1'b1, 1'b0, 32'hCAFE, 11'h7FF}) begin
            n_bad++; $display("FAIL rstmid_next_resp: got %h, expected d_ack CAFE tag 7FF", resp);
        end
        next_cycle();
        clear_inputs();
        $display("test_reset_mid done");
    endtask

    task automatic test_random(int n);
        bit ireq, dreq, drd, win_d, rerr, timed_out;
        logic [3:0]  wr;
        logic [31:0] pc, addr, wdata, rdata;
        logic [10:0] tag;
        logic [68:0] exp_mem;
        logic [45:0] exp_resp;
        int a, k, resp_w;
        do_reset();
        for (int t = 0; t < n; t++) begin
            ireq = 1'($urandom_range(0, 1));
            dreq = ireq ? 1'($urandom_range(0, 1)) : 1'b1;
            wr   = (dreq && $urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            drd  = dreq ? ((wr == 4'h0) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
            pc = $urandom; addr = $urandom; wdata = $urandom; tag = 11'($urandom);
            rdata = $urandom; rerr = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 3);
            k = $urandom_range(1, TO + 3);
            win_d = pick_data(ireq, dreq);
            exp_mem = win_d ? {drd && (wr == 4'h0), wr, addr, wdata} : {1'b1, 4'h0, pc, 32'h0};
            timed_out = (k > TO + 1);
            resp_w = timed_out ? TO + 1 : k;
            $display("txn %0d: i=%0d d=%0d wr=%h prev=%s win=%s acc_dly=%0d ack_dly=%0d%s",
                     t, ireq, dreq, wr, last_data ? "D" : "I", win_d ? "D" : "I", a, k, timed_out ? " timeout" : "");
            // Request / lock phase with stray acks that must be ignored.
            for (int c = 0; c <= a; c++) begin
                i_rd_i = ireq; i_pc_i = pc; d_rd_i = drd; d_wr_i = wr; d_addr_i = addr;
                d_data_wr_i = wdata; d_req_tag_i = tag;
                mem_accept_i = (c == a); mem_ack_i = 1'($urandom_range(0, 1)); mem_data_rd_i = $urandom;
                to_sample();
                n_cmp++;
                if (memb !== exp_mem) begin n_bad++; $display("FAIL rnd%0d_mem c%0d: got %h, expected %h", t, c, memb, exp_mem); end
                n_cmp++;
                if (acc !== ((c == a) ? {!win_d, win_d} : 2'b00)) begin
                    n_bad++; $display("FAIL rnd%0d_accept c%0d: got %b, expected %b", t, c, acc, (c == a) ? {!win_d, win_d} : 2'b00);
                end
                n_cmp++;
                if (resp !== 46'h0) begin n_bad++; $display("FAIL rnd%0d_stray c%0d: got %h, expected 0", t, c, resp); end
                next_cycle();
            end
            last_data = win_d;
            // Wait phase; the response cycle also probes the one-cycle bubble.
            clear_inputs();
            for (int w = 1; w <= resp_w; w++) begin
                mem_ack_i = (w == k);
                mem_data_rd_i = (w == k) ? rdata : $urandom;
                mem_error_i = (w == k) ? rerr : 1'($urandom_range(0, 1));
                i_rd_i = (w == resp_w); i_pc_i = 32'hBB; mem_accept_i = (w == resp_w);
                if (w == resp_w) begin
                    exp_resp = timed_out ? {!win_d, win_d, 1'b1, 32'h0, win_d ? tag : 11'h0}
                                         : {!win_d, win_d, rerr, rdata, win_d ? tag : 11'h0};
                end else begin
                    exp_resp = 46'h0;
                end
                to_sample();
                n_cmp++;
                if ({mem_rd_o, mem_wr_o} !== 5'h0) begin n_bad++; $display("FAIL rnd%0d_waitmem w%0d: got %h, expected 0", t, w, {mem_rd_o, mem_wr_o}); end
                n_cmp++;
                if (acc !== 2'b00) begin n_bad++; $display("FAIL rnd%0d_waitacc w%0d: got %b, expected 00", t, w, acc); end
                n_cmp++;
                if (resp !== exp_resp) begin n_bad++; $display("FAIL rnd%0d_resp w%0d: got %h, expected %h", t, w, resp, exp_resp); end
                next_cycle();
            end
            // Idle cycle with a late ack and no requests.
            clear_inputs();
            mem_ack_i = 1; mem_data_rd_i = $urandom; mem_accept_i = 1'($urandom_range(0, 1));
            to_sample();
            n_cmp++;
            if ({acc, resp, mem_rd_o, mem_wr_o} !== 53'h0) begin
                n_bad++; $display("FAIL rnd%0d_idle: got %h, expected 0", t, {acc, resp, mem_rd_o, mem_wr_o});
            end
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_dual_read();
        test_lock();
        test_timeout();
        test_arb_order();
        test_reset_mid();
        test_random(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
